// File: rtl/phase_to_iq_pkg.sv
// rtl/phase_to_iq_pkg.sv - shared constants, fold flags and sin/cos table generator for phase_to_iq
//
// Purpose: phase units are radians x512, so PI=1608, PI_2=804 and PI_4=402.
//   lut_entry() builds the first-octant table contents at elaboration time.
// Ports: none (package).

package phase_to_iq_pkg;

  localparam int PI                = 1608;
  localparam int PI_2              = 804;
  localparam int PI_4              = 402;
  localparam int TWO_PI            = 3216;
  localparam int PHASOR_UNIT_SHIFT = 14;
  localparam int SINCOS_LUT_LEN    = 403;

  // Fixed-point fraction bits for the elaboration-time Taylor series.
  localparam int LUT_FRAC = 40;

  typedef struct packed {
    logic sin_neg;
    logic cos_neg;
    logic swap;
  } fold_flags_t;

  // round(2^14 * sin(k/512)) or round(2^14 * cos(k/512)) for 0 <= k <= 402.
  // Because x = k/512 exactly, each Taylor term follows from the previous one
  // as term * k^2 / (512^2 * (n+1)(n+2)), which stays inside 64 bits.
  function automatic logic [14:0] lut_entry(input int k, input logic want_sin);
    longint term;
    longint sum;
    longint kk;
    int     pw;
    kk   = longint'(k) * longint'(k);
    sum  = 0;
    term = want_sin ? (longint'(k) <<< (LUT_FRAC - 9)) : (64'sd1 <<< LUT_FRAC);
    for (int i = 0; i < 20; i++) begin
      pw   = (want_sin ? 1 : 0) + 2 * i;
      sum  = (i % 2 == 0) ? sum + term : sum - term;
      term = (term * kk) / (longint'(262144) * longint'((pw + 1) * (pw + 2)));
    end
    return 15'((sum + (64'sd1 <<< (LUT_FRAC - PHASOR_UNIT_SHIFT - 1)))
               >>> (LUT_FRAC - PHASOR_UNIT_SHIFT));
  endfunction

endpackage

// File: rtl/phase_to_iq_sincos_lut.sv
// rtl/phase_to_iq_sincos_lut.sv - first-octant sin/cos ROM with registered read
//
// Purpose: sin_t[k], cos_t[k] for k in 0..402, one-cycle read latency.
// Ports:
//   clka       in   read clock
//   addra      in   table index (only 0..402 are meaningful)
//   douta_sin  out  sin_t[addra], unsigned, unit = 2^14
//   douta_cos  out  cos_t[addra], unsigned, unit = 2^14

module sincos_lut
  import phase_to_iq_pkg::*;
(
  input  logic        clka,
  input  logic [8:0]  addra,
  output logic [14:0] douta_sin,
  output logic [14:0] douta_cos
);

  // Full 9-bit address space so every address decodes; entries past the
  // octant are never addressed and read as zero.
  logic [14:0] rom_sin [0:511];
  logic [14:0] rom_cos [0:511];

  for (genvar k = 0; k < 512; k++) begin : g_rom
    if (k < SINCOS_LUT_LEN) begin : g_used
      localparam logic [14:0] SIN_V = lut_entry(k, 1'b1);
      localparam logic [14:0] COS_V = lut_entry(k, 1'b0);
      assign rom_sin[k] = SIN_V;
      assign rom_cos[k] = COS_V;
    end else begin : g_pad
      assign rom_sin[k] = 15'd0;
      assign rom_cos[k] = 15'd0;
    end
  end

  always_ff @(posedge clka) begin
    douta_sin <= rom_sin[addra];
    douta_cos <= rom_cos[addra];
  end

endmodule

// File: rtl/phase_to_iq.sv
// rtl/phase_to_iq.sv - phase (x512 rad) to unit phasor (cos,sin), with optional NCO
//
// Purpose: wraps the phase (or NCO accumulator), folds it into the first
//   octant, reads the sin/cos ROM and unfolds; 4-cycle latency, 1 sample/cycle.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   enable         0 freezes every pipeline/accumulator register
//   phase_in       phase (direct) or per-sample increment (NCO)
//   input_strobe   phase_in valid
//   nco_mode       1 = accumulate phase_in, 0 = direct
//   nco_clear      accumulator treated as zero this cycle
//   cos_out        round(16384*cos), signed OUT_WIDTH
//   sin_out        round(16384*sin), signed OUT_WIDTH
//   output_strobe  cos_out/sin_out valid, 1-cycle pulse
//   range_err      sticky: a wrap input fell outside [-2PI,2PI)

module phase_to_iq
  import phase_to_iq_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  phase_in,
  input  logic                 input_strobe,
  input  logic                 nco_mode,
  input  logic                 nco_clear,
  output logic [OUT_WIDTH-1:0] cos_out,
  output logic [OUT_WIDTH-1:0] sin_out,
  output logic                 output_strobe,
  output logic                 range_err
);

  localparam int W = IN_WIDTH + 1;
  typedef logic signed [W-1:0] wide_t;

  localparam wide_t PI_W     = wide_t'(PI);
  localparam wide_t PI_2_W   = wide_t'(PI_2);
  localparam wide_t PI_4_W   = wide_t'(PI_4);
  localparam wide_t TWO_PI_W = wide_t'(TWO_PI);

  function automatic wide_t wrap(input wide_t x);
    if (x >= PI_W)       return x - TWO_PI_W;
    else if (x < -PI_W)  return x + TWO_PI_W;
    else                 return x;
  endfunction

  function automatic logic out_of_range(input wide_t x);
    return (x >= TWO_PI_W) || (x < -TWO_PI_W);
  endfunction

  // Source select and accumulator arithmetic.
  wide_t phase_ext, acc, acc_base, acc_sum, wrap_src, p_next;
  assign phase_ext = wide_t'($signed(phase_in));
  assign acc_base  = nco_clear ? '0 : acc;
  assign acc_sum   = acc_base + phase_ext;
  assign wrap_src  = nco_mode ? acc_sum : phase_ext;
  assign p_next    = nco_mode ? acc_base : wrap(phase_ext);

  // Stage registers.
  wide_t       p1;
  logic        v1, v2, v3;
  logic [8:0]  r2, r3;
  fold_flags_t f2, f3;

  // Octant fold of the S1 phase.
  wide_t       mag, mfold;
  fold_flags_t f_fold;
  logic [8:0]  r_fold;
  always_comb begin
    mag            = p1[W-1] ? -p1 : p1;
    f_fold.sin_neg = p1[W-1];
    f_fold.cos_neg = mag > PI_2_W;
    mfold          = f_fold.cos_neg ? PI_W - mag : mag;
    f_fold.swap    = mfold > PI_4_W;
    r_fold         = 9'(f_fold.swap ? PI_2_W - mfold : mfold);
  end

  // The ROM has no enable pin: while frozen it re-reads the address it
  // already holds (r3), so its output register effectively stays put.
  logic [8:0]  lut_addr;
  logic [14:0] lut_sin, lut_cos;
  assign lut_addr = enable ? r2 : r3;

  sincos_lut u_lut (
    .clka      (clock),
    .addra     (lut_addr),
    .douta_sin (lut_sin),
    .douta_cos (lut_cos)
  );

  logic [14:0] c_sel, q_sel;
  assign c_sel = f3.swap ? lut_sin : lut_cos;
  assign q_sel = f3.swap ? lut_cos : lut_sin;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc           <= '0;
      p1            <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      r2            <= '0;
      r3            <= '0;
      f2            <= '0;
      f3            <= '0;
      cos_out       <= '0;
      sin_out       <= '0;
      output_strobe <= 1'b0;
      range_err     <= 1'b0;
    end else if (enable) begin
      v1 <= input_strobe;
      if (input_strobe) p1 <= p_next;
      if (input_strobe && out_of_range(wrap_src)) range_err <= 1'b1;
      if (input_strobe && nco_mode) acc <= wrap(acc_sum);
      else if (nco_clear)           acc <= '0;

      v2 <= v1;
      r2 <= r_fold;
      f2 <= f_fold;

      v3 <= v2;
      r3 <= r2;
      f3 <= f2;

      output_strobe <= v3;
      if (v3) begin
        cos_out <= f3.cos_neg ? -OUT_WIDTH'(c_sel) : OUT_WIDTH'(c_sel);
        sin_out <= f3.sin_neg ? -OUT_WIDTH'(q_sel) : OUT_WIDTH'(q_sel);
      end
    end else begin
      // The delay line is frozen; only the visible pulse is dropped so a
      // held v3 cannot show up as a multi-cycle or repeated strobe.
      output_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_to_iq.sv
// tb/tb_phase_to_iq.sv - self-checking bench for phase_to_iq

module tb_phase_to_iq;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] phase_in;
  logic        input_strobe;
  logic        nco_mode;
  logic        nco_clear;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        output_strobe;
  logic        range_err;

  always #5 clock = ~clock;

  phase_to_iq #(.IN_WIDTH(32), .OUT_WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .phase_in      (phase_in),
    .input_strobe  (input_strobe),
    .nco_mode      (nco_mode),
    .nco_clear     (nco_clear),
    .cos_out       (cos_out),
    .sin_out       (sin_out),
    .output_strobe (output_strobe),
    .range_err     (range_err)
  );

  typedef struct {
    int    c;
    int    s;
    int    cyc;
    int    tol;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    checks    = 0;
  int    failures  = 0;
  int    cyc       = 0;
  int    track_lat = 1;
  int    acc_m     = 0;
  int    err_m     = 0;
  int    hold_c;
  int    hold_s;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    assert (d <= tol) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return $rtoi($floor(x + 0.5));
  endfunction

  function automatic int wrap_m(input int x);
    if (x >= 1608)       return x - 3216;
    else if (x < -1608)  return x + 3216;
    else                 return x;
  endfunction

  function automatic bit oor_m(input int x);
    return (x >= 3216) || (x < -3216);
  endfunction

  // Octant-folded reference: table values from real sin/cos of r/512.
  task automatic model(input int p, output int c, output int s);
    int m, m2, r, ct, st, cc, qq;
    bit sn, cn, sw;
    sn = (p < 0);
    m  = sn ? -p : p;
    cn = (m > 804);
    m2 = cn ? 1608 - m : m;
    sw = (m2 > 402);
    r  = sw ? 804 - m2 : m2;
    ct = rnd(16384.0 * $cos(real'(r) / 512.0));
    st = rnd(16384.0 * $sin(real'(r) / 512.0));
    cc = sw ? st : ct;
    qq = sw ? ct : st;
    c  = cn ? -cc : cc;
    s  = sn ? -qq : qq;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int ph, input bit nco, input bit clr, input bit use_const,
                      input int ec, input int es, input int tol, input string tag);
    int p, c, s, base;
    phase_in     = ph;
    nco_mode     = nco;
    nco_clear    = clr;
    input_strobe = 1'b1;
    if (enable) begin
      if (nco) begin
        base  = clr ? 0 : acc_m;
        p     = base;
        if (oor_m(base + ph)) err_m = 1;
        acc_m = wrap_m(base + ph);
      end else begin
        if (oor_m(ph)) err_m = 1;
        p = wrap_m(ph);
      end
      if (use_const) begin
        c = ec;
        s = es;
      end else begin
        model(p, c, s);
      end
      sb.push_back('{c, s, (track_lat != 0) ? cyc + 4 : -1, tol, tag});
    end
    tick();
    input_strobe = 1'b0;
    nco_clear    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout got=%0d exp=0 pending", sb.size());
    end
    sb.delete();
  endtask

  // Scoreboard: compare each output_strobe against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (output_strobe === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_strobe got=1 exp=0 at cyc=%0d", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val({e.tag, "_cos"}, int'($signed(cos_out)), e.c, e.tol);
        check_val({e.tag, "_sin"}, int'($signed(sin_out)), e.s, e.tol);
        if (e.cyc >= 0) check_val({e.tag, "_latency"}, cyc, e.cyc, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    phase_in     = '0;
    input_strobe = 1'b0;
    nco_mode     = 1'b0;
    nco_clear    = 1'b0;
    tick(); tick(); tick();
    check_val("reset_cos", int'($signed(cos_out)), 0, 0);
    check_val("reset_sin", int'($signed(sin_out)), 0, 0);
    check_val("reset_strobe", int'(output_strobe), 0, 0);
    check_val("reset_range_err", int'(range_err), 0, 0);
    reset = 1'b0;
    tick();

    // Cardinal phases, back to back.
    send(0,     0, 0, 1,  16384,      0, 0, "dir_0");
    send(804,   0, 0, 1,      0,  16384, 0, "dir_804");
    send(1608,  0, 0, 1, -16384,      0, 0, "dir_1608");
    send(-804,  0, 0, 1,      0, -16384, 0, "dir_m804");
    send(-1608, 0, 0, 1, -16384,      0, 0, "dir_m1608");
    drain();

    // Octant boundaries and reflections.
    send(402,  0, 0, 0, 0, 0, 0, "dir_402");
    send(-402, 0, 0, 0, 0, 0, 0, "dir_m402");
    send(1206, 0, 0, 0, 0, 0, 0, "dir_1206");
    send(403,  0, 0, 0, 0, 0, 0, "dir_403");
    send(805,  0, 0, 0, 0, 0, 0, "dir_805");
    drain();

    // Wrap boundaries; errors only once outside [-2PI,2PI).
    send(3215,  0, 0, 0, 0, 0, 0, "wrap_3215");
    send(-3216, 0, 0, 1, 16384, 0, 0, "wrap_m3216");
    send(1607,  0, 0, 0, 0, 0, 0, "wrap_1607");
    send(-1609, 0, 0, 0, 0, 0, 0, "wrap_m1609");
    drain();
    check_val("range_err_in_range", int'(range_err), err_m, 0);
    send(3216, 0, 0, 1, 16384, 0, 0, "wrap_3216");
    drain();
    check_val("range_err_set", int'(range_err), err_m, 0);
    send(100, 0, 0, 0, 0, 0, 0, "after_err");
    drain();
    check_val("range_err_sticky", int'(range_err), 1, 0);

    // Full-circle sweep.
    for (int ph = -1608; ph < 1608; ph++) send(ph, 0, 0, 0, 0, 0, 1, "sweep");
    drain();

    // NCO: clear, then five increments of PI/2.
    nco_mode  = 1'b1;
    nco_clear = 1'b1;
    if (enable) acc_m = 0;
    tick();
    nco_clear = 1'b0;
    send(804, 1, 0, 1,  16384,      0, 0, "nco_0");
    send(804, 1, 0, 1,      0,  16384, 0, "nco_1");
    send(804, 1, 0, 1, -16384,      0, 0, "nco_2");
    send(804, 1, 0, 1,      0, -16384, 0, "nco_3");
    send(804, 1, 0, 1,  16384,      0, 0, "nco_4");
    drain();

    // Enable low mid-burst: frozen, dropped strobes, ordered resume.
    track_lat = 0;
    send(100,  0, 0, 0, 0, 0, 0, "en_a");
    send(500,  0, 0, 0, 0, 0, 0, "en_b");
    send(-900, 0, 0, 0, 0, 0, 0, "en_c");
    enable = 1'b0;
    hold_c = int'($signed(cos_out));
    hold_s = int'($signed(sin_out));
    for (int i = 0; i < 3; i++) begin
      phase_in     = 1234;
      nco_mode     = 1'b0;
      input_strobe = 1'b1;
      tick();
      check_val("frozen_strobe", int'(output_strobe), 0, 0);
      check_val("frozen_cos", int'($signed(cos_out)), hold_c, 0);
      check_val("frozen_sin", int'($signed(sin_out)), hold_s, 0);
    end
    input_strobe = 1'b0;
    enable       = 1'b1;
    send(1300, 0, 0, 0, 0, 0, 0, "en_d");
    send(-50,  0, 0, 0, 0, 0, 0, "en_e");
    drain();

    // nco_clear with strobe, then frozen accumulator across enable low.
    send(402, 1, 1, 1, 16384, 0, 0, "clr_strobe");
    send(402, 1, 0, 0, 0, 0, 0, "clr_next");
    enable       = 1'b0;
    phase_in     = 402;
    nco_mode     = 1'b1;
    input_strobe = 1'b1;
    tick();
    input_strobe = 1'b0;
    enable       = 1'b1;
    send(402, 1, 0, 1, 0, 16384, 0, "acc_frozen");
    drain();
    track_lat = 1;

    // Reset with samples in flight.
    send(700, 1, 1, 0, 0, 0, 0, "flight_a");
    send(700, 1, 0, 0, 0, 0, 0, "flight_b");
    send(700, 1, 0, 0, 0, 0, 0, "flight_c");
    reset = 1'b1;
    sb.delete();
    acc_m = 0;
    err_m = 0;
    tick();
    tick();
    check_val("mid_reset_cos", int'($signed(cos_out)), 0, 0);
    check_val("mid_reset_sin", int'($signed(sin_out)), 0, 0);
    check_val("mid_reset_strobe", int'(output_strobe), 0, 0);
    check_val("mid_reset_range_err", int'(range_err), err_m, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("post_reset_strobe", int'(output_strobe), 0, 0);
    end
    send(100, 1, 0, 1, 16384, 0, 0, "acc_after_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
